// File: rtl/noise_sched_pkg.sv
// Shared constants, FSM state type and round-robin helper for the noise
// scheduler.
package noise_sched_pkg;

  localparam int NUM_VOICES = 4;
  localparam int DIV_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    WAIT  = 2'd2,
    GRANT = 2'd3
  } state_e;

  typedef logic [1:0] voice_idx_t;

  // First pending voice at or after ptr, wrapping 3 -> 0. Returns ptr when
  // nothing is pending; callers qualify the result with |pend.
  function automatic voice_idx_t rr_pick(input logic [NUM_VOICES-1:0] pend,
                                         input voice_idx_t ptr);
    voice_idx_t pick;
    voice_idx_t idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      idx = ptr + k[1:0];
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/noise_rate_div.sv
// One voice's sample-rate divider: reloadable down-counter whose terminal
// count raises a pending request, plus a sticky overrun flag.
module noise_rate_div
  import noise_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_en_i,
  input  logic             grant_clr_i,
  output logic             pend_o,
  output logic             ovr_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    tick   = en_q && (cnt_q == '0);
    div_d  = div_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (cfg_we_i) begin
      // a write always wins over a simultaneous tick
      div_d  = cfg_div_i;
      cnt_d  = cfg_div_i;
      en_d   = cfg_en_i;
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end else begin
      if (en_q) cnt_d = tick ? div_q : cnt_q - DIV_W'(1);
      if (tick) begin
        // a tick landing on the accepting cycle is a fresh request, not an overrun
        if (pend_q && !grant_clr_i) ovr_d = 1'b1;
        pend_d = 1'b1;
      end else if (grant_clr_i) begin
        pend_d = 1'b0;
      end
    end
  end

  assign pend_o = pend_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/noise_sched.sv
// Round-robin scheduler sharing one LFSR noise source among four voices:
// step the generator, latch its word, hand it to one voice via valid/ready.
//
// state | meaning
// IDLE  | waiting for any pending voice; picks next one round-robin
// STEP  | noise_step pulse advances the generator
// WAIT  | generator output settles; latched into voice_data
// GRANT | voice_valid to the selected voice until it accepts
module noise_sched
  import noise_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           noise_in,
  output logic                  noise_step,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_sel,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic                  cfg_en,
  output logic                  voice_valid,
  output logic [NUM_VOICES-1:0] voice_grant,
  output logic [15:0]           voice_data,
  input  logic [NUM_VOICES-1:0] voice_ready,
  output logic [NUM_VOICES-1:0] ovr
);

  state_e                state_q, state_d;
  voice_idx_t            sel_q, sel_d;
  voice_idx_t            rr_ptr_q, rr_ptr_d;
  logic [15:0]           data_q, data_d;
  logic [NUM_VOICES-1:0] pend;
  logic                  accept;

  assign accept = (state_q == GRANT) && voice_ready[sel_q];

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    noise_rate_div u_div (
      .clk         (clk),
      .reset       (reset),
      .cfg_we_i    (cfg_we && (cfg_sel == voice_idx_t'(i))),
      .cfg_div_i   (cfg_div),
      .cfg_en_i    (cfg_en),
      .grant_clr_i (accept && (sel_q == voice_idx_t'(i))),
      .pend_o      (pend[i]),
      .ovr_o       (ovr[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (|pend) begin
          sel_d   = rr_pick(pend, rr_ptr_q);
          state_d = STEP;
        end
      end
      STEP: state_d = WAIT;
      WAIT: begin
        data_d  = noise_in;
        state_d = GRANT;
      end
      GRANT: begin
        if (accept) begin
          rr_ptr_d = sel_q + 2'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    noise_step  = (state_q == STEP);
    voice_valid = (state_q == GRANT);
    voice_grant = '0;
    if (state_q == GRANT) voice_grant[sel_q] = 1'b1;
  end

  assign voice_data = data_q;

endmodule

// File: tb/tb_noise_sched.sv
// Bench for noise_sched: directed scenarios plus random config/backpressure,
// compared every cycle against a per-voice behavioural model.
module tb_noise_sched;
  import noise_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] noise_in;
  logic        noise_step;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [7:0]  cfg_div = 8'd0;
  logic        cfg_en = 1'b0;
  logic        voice_valid;
  logic [3:0]  voice_grant;
  logic [15:0] voice_data;
  logic [3:0]  voice_ready = 4'h0;
  logic [3:0]  ovr;
  logic [23:0] lfsr;

  always #5 clk = ~clk;

  // stand-in 24-bit LFSR noise source
  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= 24'hACE1B5;
    else if (noise_step) lfsr <= {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
  end
  assign noise_in = lfsr[15:0];

  noise_sched dut (
    .clk         (clk),
    .reset       (reset),
    .noise_in    (noise_in),
    .noise_step  (noise_step),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_div     (cfg_div),
    .cfg_en      (cfg_en),
    .voice_valid (voice_valid),
    .voice_grant (voice_grant),
    .voice_data  (voice_data),
    .voice_ready (voice_ready),
    .ovr         (ovr)
  );

  int n_chk = 0;
  int n_pass = 0;

  // model: per-voice rate state plus a service in progress (age = cycles since pick)
  int          m_div[4];
  int          m_cnt[4];
  bit          m_en[4];
  bit          m_pend[4];
  bit          m_ovr[4];
  bit          m_busy;
  int          m_age;
  int          m_who;
  int          m_rr;
  logic [15:0] m_data;

  int steps_seen;
  int grant_log[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_div[i] = 0; m_cnt[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
    end
    m_busy = 0; m_age = 0; m_who = 0; m_rr = 0; m_data = 16'h0;
  endtask

  function automatic logic [3:0] m_ovr_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_ovr[i];
    return v;
  endfunction

  // one clock: advance the model with the inputs present at the edge, then compare
  task automatic cycle();
    logic        we;
    int          sel;
    int          cdiv;
    bit          cen;
    logic [3:0]  rdy;
    logic [15:0] ns;
    bit          accept;
    bit          served;
    bit          tk[4];
    int          pick;
    logic [3:0]  g_exp;
    we = cfg_we; sel = int'(cfg_sel); cdiv = int'(cfg_div); cen = cfg_en;
    rdy = voice_ready; ns = noise_in;
    @(posedge clk);
    #1;
    accept = m_busy && (m_age >= 3) && rdy[m_who];
    pick = -1;
    for (int k = 0; k < 4; k++)
      if (pick < 0 && m_pend[(m_rr + k) % 4]) pick = (m_rr + k) % 4;
    for (int i = 0; i < 4; i++) tk[i] = m_en[i] && (m_cnt[i] == 0);
    for (int i = 0; i < 4; i++) begin
      served = accept && (m_who == i);
      if (we && sel == i) begin
        m_div[i] = cdiv; m_en[i] = cen; m_cnt[i] = cdiv; m_pend[i] = 0; m_ovr[i] = 0;
      end else begin
        if (tk[i]) begin
          if (m_pend[i] && !served) m_ovr[i] = 1;
          m_pend[i] = 1;
        end else if (served) begin
          m_pend[i] = 0;
        end
        if (m_en[i]) m_cnt[i] = tk[i] ? m_div[i] : m_cnt[i] - 1;
      end
    end
    if (!m_busy) begin
      if (pick >= 0) begin m_busy = 1; m_age = 1; m_who = pick; end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_data = ns; m_age = 3;
    end else if (accept) begin
      grant_log.push_back(m_who);
      m_busy = 0; m_age = 0; m_rr = (m_who + 1) % 4;
    end
    if (noise_step) steps_seen++;
    g_exp = (m_busy && m_age >= 3) ? 4'(1 << m_who) : 4'h0;
    chk("noise_step", noise_step, m_busy && m_age == 1);
    chk("voice_valid", voice_valid, m_busy && m_age >= 3);
    chk("voice_grant", voice_grant, g_exp);
    chk("voice_data", voice_data, m_data);
    chk("ovr", ovr, m_ovr_vec());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cfg(input int sel, input int div, input bit en);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_div = 8'(div); cfg_en = en;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int limit);
    int n;
    n = 0;
    while (!voice_valid && n < limit) begin cycle(); n++; end
    chk(name, voice_valid, 1);
  endtask

  initial begin
    int         first;
    int         bad;
    int         per_voice[4];
    bit         ok;
    logic [15:0] hold_data;
    logic [3:0]  hold_grant;

    model_reset();
    #11;
    chk("rst_valid", voice_valid, 0);
    chk("rst_grant", voice_grant, 0);
    chk("rst_step", noise_step, 0);
    chk("rst_data", voice_data, 0);
    chk("rst_ovr", ovr, 0);
    #1 reset = 1'b1;

    // unconfigured: generator must never be stepped
    steps_seen = 0;
    run(20);
    chk("idle_no_step", steps_seen, 0);

    // single voice, period 10
    voice_ready = 4'hF;
    cfg(0, 9, 1);
    run(30);
    steps_seen = 0;
    run(100);
    chk("single_steps", steps_seen, 10);
    chk("single_ovr", ovr, 4'h0);
    cfg(0, 0, 0);
    run(10);

    // round robin, every voice ticking every cycle
    for (int v = 0; v < 4; v++) cfg(v, 0, 1);
    run(40);
    steps_seen = 0;
    grant_log.delete();
    run(64);
    chk("rr_steps", steps_seen, 16);
    chk("rr_accepts", grant_log.size(), 16);
    ok = 1;
    for (int v = 0; v < 4; v++) per_voice[v] = 0;
    foreach (grant_log[k]) begin
      per_voice[grant_log[k]]++;
      if (k > 0 && grant_log[k] != (grant_log[k-1] + 1) % 4) ok = 0;
    end
    chk("rr_order", ok, 1);
    chk("rr_per_voice0", per_voice[0], 4);
    chk("rr_per_voice3", per_voice[3], 4);
    chk("rr_ovr", ovr, 4'hF);
    for (int v = 0; v < 4; v++) cfg(v, 0, 0);
    run(10);

    // backpressure on voice 2
    voice_ready = 4'b1011;
    steps_seen = 0;
    cfg(2, 20, 1);
    wait_valid("bp_wait_valid", 40);
    hold_data = voice_data;
    hold_grant = voice_grant;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (!voice_valid || voice_grant != hold_grant || voice_data != hold_data) bad++;
    end
    chk("bp_grant", hold_grant, 4'b0100);
    chk("bp_stable", bad, 0);
    chk("bp_ovr2", ovr[2], 1);
    chk("bp_one_step", steps_seen, 1);
    voice_ready = 4'hF;
    cfg(2, 0, 0);
    run(10);

    // config write colliding with a tick on a pending, overrun voice
    voice_ready = 4'b1101;
    cfg(1, 0, 1);
    run(8);
    chk("coll_ovr_before", ovr[1], 1);
    cfg(1, 5, 1);
    chk("coll_ovr_after", ovr[1], 0);
    cycle();
    voice_ready = 4'hF;
    first = 0;
    for (int k = 3; k <= 20; k++) begin
      cycle();
      if (noise_step && first == 0) first = k;
    end
    chk("coll_first_step", first, 8);
    cfg(1, 0, 0);
    run(10);

    // voice 3 accepted exactly on its tick cycles
    cfg(3, 4, 1);
    for (int i = 0; i < 30; i++) begin
      voice_ready = {m_en[3] && m_cnt[3] == 0, 3'b111};
      cycle();
    end
    steps_seen = 0;
    for (int i = 0; i < 50; i++) begin
      voice_ready = {m_en[3] && m_cnt[3] == 0, 3'b111};
      cycle();
    end
    chk("tacc_steps", steps_seen, 10);
    chk("tacc_ovr3", ovr[3], 0);
    voice_ready = 4'hF;
    cfg(3, 0, 0);
    run(10);

    // random configuration and backpressure
    for (int i = 0; i < 500; i++) begin
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_div = 8'($urandom_range(0, 12));
      cfg_en  = ($urandom_range(0, 4) != 0);
      voice_ready = 4'($urandom);
      cycle();
    end
    cfg_we = 1'b0;

    // reset asserted in the middle of a grant
    voice_ready = 4'h0;
    cfg(0, 3, 1);
    wait_valid("rst_wait_valid", 20);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_valid", voice_valid, 0);
    chk("rst_mid_grant", voice_grant, 0);
    chk("rst_mid_step", noise_step, 0);
    chk("rst_mid_data", voice_data, 0);
    chk("rst_mid_ovr", ovr, 0);
    model_reset();
    #2 reset = 1'b1;
    voice_ready = 4'hF;
    steps_seen = 0;
    run(20);
    chk("post_rst_no_step", steps_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
